mem_stage_responder: RTL and testbench
======================================

// Module: mem_stage_responder
// PURPOSE
//  Responder side of the ALU memory-op interface (memOp.addr/memRead/rdAddr).
//  Accepts one load/store request at a time and services it against an internal
//  word-organised data RAM. Loads return write-back data (rdAddr, data) to the
//  register file; stores are applied with byte enables.
//  Sits between the ALU/EX stage and the register-file write-back port.
// PARAMETERS
//  ADDR_W      32  request address width (byte address)
//  DATA_W      32  data word width (fixed 32; RV32 sizes only)
//  REGADDR_W    5  destination register index width
//  MEM_DEPTH_W 10  log2(RAM depth in words); RAM = 2**MEM_DEPTH_W x 32
// PORTS
//  iClk         in   1          clock, all state on rising edge
//  iRst         in   1          asynchronous, active-low reset
//  iReqValid    in   1          request valid
//  oReqReady    out  1          responder can accept a request this cycle
//  iReqRead     in   1          load request
//  iReqWrite    in   1          store request
//  iReqAddr     in   ADDR_W     byte address (rs1 + imm from ALU)
//  iReqWData    in   32         store data (rs2), LSB-aligned
//  iReqFunct3   in   3          size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  iReqRdAddr   in   REGADDR_W  load destination register
//  oWbValid     out  1          write-back pulse, 1 cycle
//  oWbRdAddr    out  REGADDR_W  write-back register index
//  oWbData      out  32         write-back data, sign/zero extended
//  oReqErr      out  1          1-cycle pulse: misaligned/illegal request
// BEHAVIOUR
//  Reset (iRst=0, async): state IDLE; oReqReady=0 during reset, 1 in first
//   cycle after release; oWbValid, oWbRdAddr, oWbData, oReqErr = 0.
//   RAM contents not reset. Reset mid-request aborts it; no write-back, no
//   partial store (store commits only on the WR edge).
//  Accept: iReqValid && oReqReady sampled on rising edge. oReqReady = (state==IDLE).
//  FSM: IDLE, RD, WB, WR, ERR.
//   IDLE: legal load -> RD; legal store -> WR; illegal -> ERR; else stay.
//   RD : RAM read of word addr[MEM_DEPTH_W+1:2] issued; -> WB.
//   WB : oWbValid=1 with extracted data, oWbRdAddr=captured rd; -> IDLE.
//   WR : RAM write with byte enables on this edge; -> IDLE. No write-back.
//   ERR: oReqErr=1 for this cycle; no RAM access, no write-back; -> IDLE.
//  Latency: load accepted at edge k -> oWbValid high in cycle after edge k+2;
//   store occupies 2 cycles; ready rises again in the cycle after WB/WR/ERR.
//  Request fields captured at accept; inputs ignored outside IDLE.
//  Illegal: iReqRead&&iReqWrite; neither set with valid; funct3 not in list
//   (stores: only 000/001/010); H/HU with addr[0]=1; W with addr[1:0]!=0.
//  Load extract: byte lane addr[1:0], halfword lane addr[1]; B/H sign-extend,
//   BU/HU zero-extend, W as-is.
//  Store: SB byte enable 1<<addr[1:0], data replicated to all lanes;
//   SH enables 0011/1100 by addr[1]; SW 1111.
//  rd==0 load: RAM read performed, oWbValid suppressed (stays 0).
//  Address bits above MEM_DEPTH_W+1 ignored (address aliases/wraps).
//  oWbData/oWbRdAddr hold last value when oWbValid=0.
// TESTING
//  SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 rd=5 -> oWbValid 1 cycle,
//   rd=5, data 0xDEADBEEF, exactly 2 cycles after load accept edge.
//  SB 0x80 to addr 0x13, LB/LBU addr 0x13 -> 0xFFFFFF80 / 0x00000080;
//   LW 0x10 -> 0x80ADBEEF.
//  LH addr 0x11 rd=3 -> oReqErr pulse, no oWbValid; next SW 0x12 -> err, RAM unchanged.
//  iReqValid held high back-to-back: oReqReady low in RD/WB/WR; no request
//   lost or duplicated across 4 mixed loads/stores.
//  LW rd=0 -> no oWbValid; read/write both set -> oReqErr.
//  iRst asserted in RD -> outputs 0 immediately, no write-back after release;
//   iRst asserted in WR before edge -> RAM word unchanged.

Source files
------------

// File: rtl/mem_stage_responder.sv
// Load/store responder: accepts one memory request at a time and services it against
// a word-organised RAM with byte enables. Loads return sign/zero-extended data for write-back.
module mem_stage_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REGADDR_W   = 5,
  parameter int MEM_DEPTH_W = 10
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iReqValid,
  output logic                 oReqReady,
  input  logic                 iReqRead,
  input  logic                 iReqWrite,
  input  logic [ADDR_W-1:0]    iReqAddr,
  input  logic [DATA_W-1:0]    iReqWData,
  input  logic [2:0]           iReqFunct3,
  input  logic [REGADDR_W-1:0] iReqRdAddr,
  output logic                 oWbValid,
  output logic [REGADDR_W-1:0] oWbRdAddr,
  output logic [DATA_W-1:0]    oWbData,
  output logic                 oReqErr
);

  localparam int LOW_W = MEM_DEPTH_W + 2;

  typedef enum logic [2:0] {IDLE, RD, WB, WR, ERR} stateT;

  stateT                  state;
  logic [LOW_W-1:0]       reqAddr;
  logic [DATA_W-1:0]      reqWData;
  logic [2:0]             reqFunct3;
  logic [REGADDR_W-1:0]   reqRdAddr;
  logic [DATA_W-1:0]      ramData;
  logic [DATA_W-1:0]      mem [0:(2**MEM_DEPTH_W)-1];
  logic [MEM_DEPTH_W-1:0] wordAddr;
  logic                   reqLegal;
  logic                   misaligned;
  logic                   f3OkLoad;
  logic                   f3OkStore;
  logic [DATA_W-1:0]      loadData;
  logic [DATA_W-1:0]      storeData;
  logic [3:0]             byteEn;
  logic [7:0]             byteSel;
  logic [15:0]            halfSel;
  logic                   unusedAddrBits;

  // Address bits above the RAM range are deliberately dropped so accesses alias.
  assign unusedAddrBits = ^iReqAddr[ADDR_W-1:LOW_W];
  assign wordAddr       = reqAddr[LOW_W-1:2];
  assign oReqReady      = iRst && (state == IDLE);

  always_comb begin
    f3OkLoad   = (iReqFunct3 == 3'b000) || (iReqFunct3 == 3'b001) || (iReqFunct3 == 3'b010) ||
                 (iReqFunct3 == 3'b100) || (iReqFunct3 == 3'b101);
    f3OkStore  = (iReqFunct3 == 3'b000) || (iReqFunct3 == 3'b001) || (iReqFunct3 == 3'b010);
    misaligned = ((iReqFunct3[1:0] == 2'b01) && iReqAddr[0]) ||
                 ((iReqFunct3[1:0] == 2'b10) && (iReqAddr[1:0] != 2'b00));
    reqLegal   = (iReqRead ^ iReqWrite) && (iReqRead ? f3OkLoad : f3OkStore) && !misaligned;
  end

  always_comb begin
    byteSel  = ramData[{reqAddr[1:0], 3'b000} +: 8];
    halfSel  = reqAddr[1] ? ramData[31:16] : ramData[15:0];
    loadData = ramData;
    case (reqFunct3)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadData = {24'd0, byteSel};
      3'b101:  loadData = {16'd0, halfSel};
      default: loadData = ramData;
    endcase
  end

  always_comb begin
    storeData = reqWData;
    byteEn    = 4'b1111;
    case (reqFunct3[1:0])
      2'b00: begin
        storeData = {4{reqWData[7:0]}};
        byteEn    = 4'b0001 << reqAddr[1:0];
      end
      2'b01: begin
        storeData = {2{reqWData[15:0]}};
        byteEn    = reqAddr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        storeData = reqWData;
        byteEn    = 4'b1111;
      end
    endcase
  end

  // The RAM is never reset; an async reset forces the state out of WR, so no partial store.
  always_ff @(posedge iClk) begin
    if (state == RD) ramData <= mem[wordAddr];
    if (state == WR) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordAddr][8*b +: 8] <= storeData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state     <= IDLE;
      reqAddr   <= '0;
      reqWData  <= '0;
      reqFunct3 <= '0;
      reqRdAddr <= '0;
      oWbValid  <= 1'b0;
      oWbRdAddr <= '0;
      oWbData   <= '0;
      oReqErr   <= 1'b0;
    end else begin
      oWbValid <= 1'b0;
      oReqErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (iReqValid) begin
            reqAddr   <= iReqAddr[LOW_W-1:0];
            reqWData  <= iReqWData;
            reqFunct3 <= iReqFunct3;
            reqRdAddr <= iReqRdAddr;
            if (!reqLegal)     state <= ERR;
            else if (iReqRead) state <= RD;
            else               state <= WR;
          end
        end
        RD: state <= WB;
        WB: begin
          // Writes to x0 still read the RAM but never reach the register file.
          if (reqRdAddr != '0) begin
            oWbValid  <= 1'b1;
            oWbRdAddr <= reqRdAddr;
            oWbData   <= loadData;
          end
          state <= IDLE;
        end
        WR: state <= IDLE;
        ERR: begin
          oReqErr <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_responder.sv
// Directed bench for mem_stage_responder: loads, stores, illegal requests,
// back-to-back traffic and reset aborts, each against hand-computed values.
module tb_mem_stage_responder;

  logic        iClk;
  logic        iRst;
  logic        iReqValid;
  logic        oReqReady;
  logic        iReqRead;
  logic        iReqWrite;
  logic [31:0] iReqAddr;
  logic [31:0] iReqWData;
  logic [2:0]  iReqFunct3;
  logic [4:0]  iReqRdAddr;
  logic        oWbValid;
  logic [4:0]  oWbRdAddr;
  logic [31:0] oWbData;
  logic        oReqErr;

  int vectors;
  int miscompares;
  logic [36:0] wbLog[$];

  mem_stage_responder dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iReqValid  (iReqValid),
    .oReqReady  (oReqReady),
    .iReqRead   (iReqRead),
    .iReqWrite  (iReqWrite),
    .iReqAddr   (iReqAddr),
    .iReqWData  (iReqWData),
    .iReqFunct3 (iReqFunct3),
    .iReqRdAddr (iReqRdAddr),
    .oWbValid   (oWbValid),
    .oWbRdAddr  (oWbRdAddr),
    .oWbData    (oWbData),
    .oReqErr    (oReqErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge, logging write-backs.
  task automatic tick();
    @(posedge iClk);
    #1;
    if (oWbValid === 1'b1) wbLog.push_back({oWbRdAddr, oWbData});
  endtask

  task automatic applyStimulus(input logic valid, input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3, input logic [4:0] rdAddr);
    iReqValid  = valid;
    iReqRead   = rd;
    iReqWrite  = wr;
    iReqAddr   = addr;
    iReqWData  = wdata;
    iReqFunct3 = f3;
    iReqRdAddr = rdAddr;
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0);
  endtask

  task automatic doStore(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, data, f3, 5'd0);
    tick();
    idleBus();
    checkOutput({tag, "_busy"}, oReqReady, 1'b0);
    tick();
    checkOutput({tag, "_ready"}, oReqReady, 1'b1);
    checkOutput({tag, "_nowb"}, oWbValid, 1'b0);
  endtask

  task automatic doLoad(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [4:0] rdAddr, input logic [31:0] expData);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'h0, f3, rdAddr);
    tick();
    idleBus();
    checkOutput({tag, "_rdbusy"}, oReqReady, 1'b0);
    tick();
    checkOutput({tag, "_wbearly"}, oWbValid, 1'b0);
    tick();
    checkOutput({tag, "_wbvalid"}, oWbValid, (rdAddr != 5'd0));
    checkOutput({tag, "_data"}, oWbData, expData);
    if (rdAddr != 5'd0) checkOutput({tag, "_rd"}, oWbRdAddr, rdAddr);
    tick();
    checkOutput({tag, "_pulse"}, oWbValid, 1'b0);
  endtask

  task automatic doIllegal(input string tag, input logic rd, input logic wr, input logic [31:0] addr, input logic [2:0] f3);
    applyStimulus(1'b1, rd, wr, addr, 32'h0, f3, 5'd3);
    tick();
    idleBus();
    checkOutput({tag, "_errearly"}, oReqErr, 1'b0);
    tick();
    checkOutput({tag, "_err"}, oReqErr, 1'b1);
    checkOutput({tag, "_nowb"}, oWbValid, 1'b0);
    tick();
    checkOutput({tag, "_errpulse"}, oReqErr, 1'b0);
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (oReqReady !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, "_wait"}, oReqReady, 1'b1);
  endtask

  task automatic issueHeld(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] f3, input logic [4:0] rdAddr);
    applyStimulus(1'b1, rd, wr, addr, data, f3, rdAddr);
    waitReady(tag);
    tick();
    checkOutput({tag, "_busy"}, oReqReady, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    iRst        = 1'b0;
    idleBus();

    #3;
    checkOutput("rst_ready", oReqReady, 1'b0);
    checkOutput("rst_wbvalid", oWbValid, 1'b0);
    checkOutput("rst_err", oReqErr, 1'b0);
    checkOutput("rst_data", oWbData, 32'h0);
    checkOutput("rst_rd", oWbRdAddr, 5'd0);
    tick();
    tick();
    iRst = 1'b1;
    #1;
    checkOutput("rel_ready", oReqReady, 1'b1);

    doStore("sw10", 32'h10, 32'hDEADBEEF, 3'b010);
    doLoad("lw10", 32'h10, 3'b010, 5'd5, 32'hDEADBEEF);
    checkOutput("hold_data", oWbData, 32'hDEADBEEF);
    checkOutput("hold_rd", oWbRdAddr, 5'd5);

    doStore("sb13", 32'h13, 32'h00000080, 3'b000);
    doLoad("lb13", 32'h13, 3'b000, 5'd6, 32'hFFFFFF80);
    doLoad("lbu13", 32'h13, 3'b100, 5'd6, 32'h00000080);
    doLoad("lw10b", 32'h10, 3'b010, 5'd4, 32'h80ADBEEF);
    doLoad("lh12", 32'h12, 3'b001, 5'd7, 32'hFFFF80AD);
    doLoad("lhu10", 32'h10, 3'b101, 5'd8, 32'h0000BEEF);
    doLoad("alias", 32'h1010, 3'b010, 5'd9, 32'h80ADBEEF);

    doIllegal("lh11", 1'b1, 1'b0, 32'h11, 3'b001);
    doIllegal("sw12", 1'b0, 1'b1, 32'h12, 3'b010);
    doLoad("lw10c", 32'h10, 3'b010, 5'd10, 32'h80ADBEEF);
    doLoad("lwrd0", 32'h10, 3'b010, 5'd0, 32'h80ADBEEF);
    doIllegal("rdwr", 1'b1, 1'b1, 32'h10, 3'b010);
    doIllegal("none", 1'b0, 1'b0, 32'h10, 3'b010);
    doIllegal("ldf3", 1'b1, 1'b0, 32'h10, 3'b011);
    doIllegal("sbu", 1'b0, 1'b1, 32'h10, 3'b100);

    wbLog.delete();
    issueHeld("b2b_sw", 1'b0, 1'b1, 32'h20, 32'h11223344, 3'b010, 5'd0);
    issueHeld("b2b_lw1", 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 5'd1);
    issueHeld("b2b_sb", 1'b0, 1'b1, 32'h21, 32'h000000AA, 3'b000, 5'd0);
    issueHeld("b2b_lw2", 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 5'd2);
    idleBus();
    tick();
    tick();
    tick();
    checkOutput("b2b_count", wbLog.size(), 2);
    if (wbLog.size() == 2) begin
      checkOutput("b2b_wb1", wbLog[0], {5'd1, 32'h11223344});
      checkOutput("b2b_wb2", wbLog[1], {5'd2, 32'h1122AA44});
    end

    wbLog.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 5'd9);
    tick();
    idleBus();
    #2;
    iRst = 1'b0;
    #1;
    checkOutput("rstrd_ready", oReqReady, 1'b0);
    checkOutput("rstrd_wbvalid", oWbValid, 1'b0);
    checkOutput("rstrd_data", oWbData, 32'h0);
    checkOutput("rstrd_rd", oWbRdAddr, 5'd0);
    tick();
    iRst = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("rstrd_nowb", wbLog.size(), 0);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 32'h12345678, 3'b010, 5'd0);
    tick();
    idleBus();
    #2;
    iRst = 1'b0;
    tick();
    iRst = 1'b1;
    tick();
    doLoad("rstwr", 32'h10, 3'b010, 5'd11, 32'h80ADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
